// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-memory fetch arbiter.
package imem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int REQ_IF  = 0;
  localparam int REQ_DBG = 1;
  localparam int N_REQ   = 2;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin grant: rr_ptr breaks the tie when both request.
module rr_arbiter2
  import imem_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req_valid,
  input  logic             rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic             winner,
  output logic             any_req
);

  always_comb begin
    any_req = |req_valid;
    if (req_valid == 2'b11) begin
      winner = rr_ptr;
    end else begin
      winner = req_valid[REQ_DBG];
    end
    grant = any_req ? (N_REQ'(1) << winner) : '0;
  end

endmodule

// File: rtl/imem_fetch_arbiter.sv
// Shares the read-only instruction memory port between the IF fetch unit and the debug port,
// sequencing ENABLE/ADDRESS, waiting for DATA_READY and bounding each access with a timeout.
module imem_fetch_arbiter
  import imem_arb_pkg::*;
#(
  parameter int WORD_SIZE    = 32,
  parameter int ADDRESS_SIZE = 16,
  parameter int TIMEOUT      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [ADDRESS_SIZE-1:0] req_addr0,
  input  logic [ADDRESS_SIZE-1:0] req_addr1,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [WORD_SIZE-1:0]    rsp_data,
  output logic                    rsp_err,
  input  logic                    flush,
  output logic                    mem_enable,
  output logic [ADDRESS_SIZE-1:0] mem_address,
  input  logic                    mem_data_ready,
  input  logic [WORD_SIZE-1:0]    mem_data,
  output logic                    busy
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t                  state_reg;
  state_t                  state_next;
  logic                    rr_ptr_reg;
  logic                    owner_reg;
  logic                    cancel_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic [ADDRESS_SIZE-1:0] addr_reg;
  logic [WORD_SIZE-1:0]    rsp_data_reg;
  logic                    rsp_err_reg;

  logic [N_REQ-1:0] grant;
  logic             winner;
  logic             any_req;
  logic             data_ok;
  logic             timeout_hit;
  logic             kill;

  rr_arbiter2 u_rr (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_reg),
    .grant     (grant),
    .winner    (winner),
    .any_req   (any_req)
  );

  // A ready seen in the first WAIT cycle may be left over from the previous access.
  assign data_ok     = (cnt_reg != '0) && mem_data_ready;
  assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT - 1));
  assign kill        = flush && (owner_reg == 1'(REQ_IF));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_req) state_next = WAIT;
      WAIT:    if (data_ok || timeout_hit) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_enable  = 1'b0;
    mem_address = '0;
    req_ready   = '0;
    rsp_valid   = '0;
    case (state_reg)
      IDLE: req_ready = grant;
      WAIT: begin
        mem_enable  = 1'b1;
        mem_address = addr_reg;
      end
      RESP: if (!(cancel_reg || kill)) rsp_valid = N_REQ'(1) << owner_reg;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_reg   <= 1'b0;
      owner_reg    <= 1'b0;
      cancel_reg   <= 1'b0;
      cnt_reg      <= '0;
      addr_reg     <= '0;
      rsp_data_reg <= '0;
      rsp_err_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            addr_reg   <= winner ? req_addr1 : req_addr0;
            owner_reg  <= winner;
            cnt_reg    <= '0;
            cancel_reg <= 1'b0;
          end
        end
        WAIT: begin
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (kill) cancel_reg <= 1'b1;
          if (data_ok) begin
            rsp_data_reg <= mem_data;
            rsp_err_reg  <= 1'b0;
          end else if (timeout_hit) begin
            rsp_data_reg <= '0;
            rsp_err_reg  <= !(cancel_reg || kill);
          end
        end
        RESP: begin
          if (kill) cancel_reg <= 1'b1;
          rr_ptr_reg <= ~owner_reg;
        end
        default: ;
      endcase
    end
  end

  assign rsp_data = rsp_data_reg;
  assign rsp_err  = rsp_err_reg;
  assign busy     = (state_reg != IDLE);

endmodule
